// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type plus the instruction-cache address split, frame and FSM state types.
package cpu_types_pkg;

    localparam int WORD_W       = 32;
    localparam int ICACHE_IDX_W = 4;
    localparam int ICACHE_TAG_W = WORD_W - ICACHE_IDX_W - 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_stats.sv
// Saturating hit/miss counters for the instruction cache (built only with ICACHE_STATS_EN).
module icache_stats
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  hit_inc,
    input  logic  miss_inc,
    output word_t hit_count,
    output word_t miss_count
);

    word_t hit_q;
    word_t miss_q;

    always_ff @(posedge CLK) begin
        if (nRST) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (hit_inc && (hit_q != '1)) begin
                hit_q <= hit_q + 32'd1;
            end
            if (miss_inc && (miss_q != '1)) begin
                miss_q <= miss_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with single-word refills.
// Optional hit/miss statistics are enabled by defining ICACHE_STATS_EN.
module icache
    import cpu_types_pkg::*;
#(
    parameter int NFRAMES = 16,
    parameter int IDX_W   = $clog2(NFRAMES)
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    input  logic  iwait,
    input  word_t iload,
    output logic  iREN,
    output word_t iaddr
`ifdef ICACHE_STATS_EN
    ,
    output word_t hit_count,
    output word_t miss_count
`endif
);

    localparam int TAG_W = WORD_W - IDX_W - 2;

    icache_state_t state_q, state_d;
    logic [WORD_W-1:2] miss_addr_q;

    logic [NFRAMES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_mem  [NFRAMES];
    word_t              data_mem [NFRAMES];

    logic [IDX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic             miss_start;
    logic             fill;
    logic             unused_bytoff;

    assign req_idx       = imemaddr[IDX_W+1:2];
    assign req_tag       = imemaddr[WORD_W-1:IDX_W+2];
    assign fill_idx      = miss_addr_q[IDX_W+1:2];
    assign fill_tag      = miss_addr_q[WORD_W-1:IDX_W+2];
    assign unused_bytoff = ^imemaddr[1:0];

    always_comb begin
        state_d    = state_q;
        miss_start = 1'b0;
        fill       = 1'b0;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        case (state_q)
            IDLE: begin
                if (imemREN) begin
                    if (valid_q[req_idx] && (tag_mem[req_idx] == req_tag)) begin
                        ihit     = 1'b1;
                        imemload = data_mem[req_idx];
                    end else begin
                        miss_start = 1'b1;
                        state_d    = MISS;
                    end
                end
            end
            MISS: begin
                iREN  = 1'b1;
                iaddr = {miss_addr_q, 2'b00};
                if (!iwait) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                miss_addr_q <= imemaddr[WORD_W-1:2];
            end
            if (fill) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag/data arrays are unreset; reset still blocks a coincident fill.
    always_ff @(posedge CLK) begin
        if (fill && !nRST) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    icache_stats u_stats (
        .CLK        (CLK),
        .nRST       (nRST),
        .hit_inc    (ihit),
        .miss_inc   (miss_start),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache; statistics checks compile in with ICACHE_STATS_EN.
module tb_icache;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iwait;
    word_t iload;
    logic  iREN;
    word_t iaddr;
`ifdef ICACHE_STATS_EN
    word_t hit_count;
    word_t miss_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    icache #(.NFRAMES(16)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iwait      (iwait),
        .iload      (iload),
        .iREN       (iREN),
        .iaddr      (iaddr)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input word_t obs, input word_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Detect cycle, `waits` stalled MISS cycles, then the fill cycle.
    task automatic do_miss(input string tag, input word_t addr, input word_t exp_iaddr,
                           input word_t data, input int waits);
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        iload    = '0;
        @(negedge CLK);
        check_eq({tag, "_det_ihit"}, 32'(ihit), 32'd0);
        check_eq({tag, "_det_iren"}, 32'(iREN), 32'd0);
        next_cycle();
        for (int i = 0; i < waits; i++) begin
            @(negedge CLK);
            check_eq({tag, "_wait_iren"},  32'(iREN), 32'd1);
            check_eq({tag, "_wait_iaddr"}, iaddr, exp_iaddr);
            check_eq({tag, "_wait_ihit"},  32'(ihit), 32'd0);
            next_cycle();
        end
        iwait = 1'b0;
        iload = data;
        @(negedge CLK);
        check_eq({tag, "_fill_iren"},  32'(iREN), 32'd1);
        check_eq({tag, "_fill_iaddr"}, iaddr, exp_iaddr);
        next_cycle();
        iwait = 1'b1;
        iload = '0;
    endtask

    task automatic expect_hit(input string tag, input word_t addr, input word_t data);
        imemREN  = 1'b1;
        imemaddr = addr;
        @(negedge CLK);
        check_eq({tag, "_ihit"}, 32'(ihit), 32'd1);
        check_eq({tag, "_load"}, imemload, data);
        check_eq({tag, "_iren"}, 32'(iREN), 32'd0);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        nRST     = 1'b1;
        imemREN  = 1'b0;
        imemaddr = '0;
        iwait    = 1'b1;
        iload    = '0;
        next_cycle();
        next_cycle();
        @(negedge CLK);
        check_eq("rst_ihit",  32'(ihit), 32'd0);
        check_eq("rst_load",  imemload, 32'd0);
        check_eq("rst_iren",  32'(iREN), 32'd0);
        check_eq("rst_iaddr", iaddr, 32'd0);
`ifdef ICACHE_STATS_EN
        check_eq("rst_hitcnt",  hit_count, 32'd0);
        check_eq("rst_misscnt", miss_count, 32'd0);
`endif
        next_cycle();
        nRST = 1'b0;

        // Cold miss: three refill cycles, then hit.
        do_miss("cold", 32'h0000_0040, 32'h0000_0040, 32'h2001_0005, 2);
        expect_hit("cold_hit", 32'h0000_0040, 32'h2001_0005);

        // Idle with no request.
        imemREN  = 1'b0;
        imemaddr = 32'h0000_0040;
        @(negedge CLK);
        check_eq("noreq_ihit", 32'(ihit), 32'd0);
        check_eq("noreq_load", imemload, 32'd0);
        next_cycle();

        // Conflict eviction on index 1.
        do_miss("cf04", 32'h0000_0004, 32'h0000_0004, 32'hAAAA_0004, 0);
        expect_hit("cf04_hit", 32'h0000_0004, 32'hAAAA_0004);
        do_miss("cf44", 32'h0000_0044, 32'h0000_0044, 32'hBBBB_0044, 0);
        expect_hit("cf44_hit", 32'h0000_0044, 32'hBBBB_0044);
        do_miss("cf04b", 32'h0000_0004, 32'h0000_0004, 32'hAAAA_1004, 0);
        expect_hit("cf04b_hit", 32'h0000_0004, 32'hAAAA_1004);
        expect_hit("idx0_kept", 32'h0000_0040, 32'h2001_0005);

        // Address change (and request drop) mid-miss.
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0010;
        @(negedge CLK);
        check_eq("chg_det_ihit", 32'(ihit), 32'd0);
        next_cycle();
        imemaddr = 32'h0000_0020;
        imemREN  = 1'b0;
        @(negedge CLK);
        check_eq("chg_wait_iaddr", iaddr, 32'h0000_0010);
        check_eq("chg_wait_iren",  32'(iREN), 32'd1);
        next_cycle();
        iwait = 1'b0;
        iload = 32'hCCCC_0010;
        @(negedge CLK);
        check_eq("chg_fill_iaddr", iaddr, 32'h0000_0010);
        next_cycle();
        iwait = 1'b1;
        do_miss("chg20", 32'h0000_0020, 32'h0000_0020, 32'hDDDD_0020, 0);
        expect_hit("chg10_hit", 32'h0000_0010, 32'hCCCC_0010);
        expect_hit("chg20_hit", 32'h0000_0020, 32'hDDDD_0020);

        // Reset while stalled in MISS.
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0030;
        next_cycle();
        @(negedge CLK);
        check_eq("rmiss_iren", 32'(iREN), 32'd1);
        next_cycle();
        nRST    = 1'b1;
        imemREN = 1'b0;
        next_cycle();
        nRST = 1'b0;
        @(negedge CLK);
        check_eq("rmiss_iren_drop",  32'(iREN), 32'd0);
        check_eq("rmiss_iaddr_drop", iaddr, 32'd0);
        next_cycle();
        do_miss("rmiss_refetch40", 32'h0000_0040, 32'h0000_0040, 32'h2001_0005, 0);
        expect_hit("rmiss_hit40", 32'h0000_0040, 32'h2001_0005);

        // Reset coinciding with refill completion writes nothing.
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0030;
        next_cycle();
        nRST  = 1'b1;
        iwait = 1'b0;
        iload = 32'hEEEE_0030;
        next_cycle();
        nRST  = 1'b0;
        iwait = 1'b1;
        iload = '0;
        do_miss("rprio30", 32'h0000_0030, 32'h0000_0030, 32'h1111_0030, 0);
        expect_hit("rprio30_hit", 32'h0000_0030, 32'h1111_0030);

        // Byte offset is ignored.
        do_miss("boff", 32'h0000_0008, 32'h0000_0008, 32'h1234_5678, 1);
        expect_hit("boff_0b", 32'h0000_000B, 32'h1234_5678);
        expect_hit("boff_09", 32'h0000_0009, 32'h1234_5678);

`ifdef ICACHE_STATS_EN
        imemREN = 1'b0;
        nRST    = 1'b1;
        next_cycle();
        nRST = 1'b0;
        @(negedge CLK);
        check_eq("st_clr_hit",  hit_count, 32'd0);
        check_eq("st_clr_miss", miss_count, 32'd0);
        next_cycle();
        do_miss("st", 32'h0000_0050, 32'h0000_0050, 32'h5555_0050, 0);
        for (int i = 0; i < 5; i++) begin
            expect_hit("st_hit", 32'h0000_0050, 32'h5555_0050);
        end
        imemREN = 1'b0;
        @(negedge CLK);
        check_eq("st_hitcnt",  hit_count, 32'd5);
        check_eq("st_misscnt", miss_count, 32'd1);
        force dut.u_stats.hit_q = 32'hFFFF_FFFF;
        next_cycle();
        release dut.u_stats.hit_q;
        expect_hit("st_sat_hit", 32'h0000_0050, 32'h5555_0050);
        imemREN = 1'b0;
        @(negedge CLK);
        check_eq("st_sat", hit_count, 32'hFFFF_FFFF);
        next_cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache answering the datapath's instruction-fetch requests on the `datapath_cache_if` instruction side. It also issues single-word refills to the memory controller on the `caches_if` instruction side. It sits between the pipelined datapath's fetch stage and the memory arbiter. A hit answers in the same cycle. A miss stalls fetch by withholding `ihit` until the refill completes.

## Interface
Parameters:
- `NFRAMES`, 16: number of one-word frames; power of two, minimum 2.
- `IDX_W`, `$clog2(NFRAMES)`: index width.

Ports:
- `CLK`, in, 1: clock; all state updates on the rising edge.
- `nRST`, in, 1: reset. Synchronous and active-high: a 1 sampled at the rising edge resets the block.
- `imemREN`, in, 1: the datapath requests an instruction.
- `imemaddr`, in, 32: byte address of the fetch; bits [1:0] are ignored.
- `ihit`, out, 1: `imemload` is valid this cycle.
- `imemload`, out, 32: fetched instruction.
- `iwait`, in, 1: the memory controller is busy; `iload` is not yet valid.
- `iload`, in, 32: refill data from memory.
- `iREN`, out, 1: refill read request.
- `iaddr`, out, 32: refill word address, with bits [1:0] = 0.
- `hit_count`, out, 32: present only with `ICACHE_STATS_EN`.
- `miss_count`, out, 32: present only with `ICACHE_STATS_EN`.

## Operation
Address split:
- tag = `imemaddr[31:IDX_W+2]`
- index = `imemaddr[IDX_W+1:2]`
- byte offset = `[1:0]`

Each frame holds a valid bit, a tag and one data word.

State machine, states `IDLE` and `MISS`:
- **IDLE:**
  - A hit is `imemREN` && frame[index].valid && frame[index].tag == tag.
  - On a hit: `ihit`=1 and `imemload`=frame data, combinationally. State is unchanged.
  - On `imemREN` without a hit: latch `imemaddr` into `miss_addr` and go to `MISS`. `ihit`=0 that cycle.
  - When `imemREN`=0: `ihit`=0 and no transition.
- **MISS:**
  - `iREN`=1 and `iaddr`={`miss_addr[31:2]`, 2'b00}.
  - On a cycle with `iwait`=0: write frame[`miss_addr` index] with valid=1, tag from `miss_addr`, data=`iload`, then go to `IDLE`.
  - `ihit` stays 0 throughout `MISS`.

Output rules:
- `imemload` is 0 whenever `ihit`=0.
- `iREN`=0 and `iaddr`=0 whenever the state is not `MISS`.

Boundary conditions:
- If `imemREN` drops or `imemaddr` changes during `MISS`, the refill still completes using the latched `miss_addr`. It is never aborted.
- A refill overwrites a valid frame with a different tag (conflict eviction). No write-back is needed, since the cache is read-only.
- Reset asserted during `MISS`: the state returns to `IDLE`, all valid bits clear, and `iREN` drops the next cycle. The memory controller must tolerate a dropped request.
- Reset has priority over a simultaneous refill-complete: nothing is written.

## Timing
- Hit latency is 0 cycles: `ihit` is asserted in the same cycle as the request.
- Miss latency: 1 cycle in `IDLE` detecting the miss, then the `MISS` cycles until `iwait`=0 (fill on that edge), then 1 cycle in `IDLE` that hits.
  - With `iwait` low on the first `MISS` cycle, the total is 3 cycles from request to `ihit`.
- Reset values:
  - state = `IDLE`
  - all valid bits = 0
  - `ihit`=0, `imemload`=0, `iREN`=0, `iaddr`=0
  - `hit_count`=0, `miss_count`=0
- Tag and data storage need no reset.

## Configuration
- `ICACHE_STATS_EN` defined: two 32-bit saturating counters.
  - `hit_count` increments on each IDLE cycle with `ihit`=1.
  - `miss_count` increments on each IDLE→MISS transition.
  - Both hold at 32'hFFFF_FFFF once reached.
  - Both clear on reset.
- Undefined: the counters and both ports are absent. Cache behaviour is identical either way.

## Structure
- `cpu_types_pkg` gets:
  - `icachef_t`: packed tag/idx/bytoff split of a word address.
  - `icache_frame_t`: valid, tag, data.
  - `icache_state_t`: enum of `IDLE` and `MISS`.
- Width constants derive from `NFRAMES` in the module; `word_t` comes from the package.
- One sub-module, `icache_stats`, holds the two saturating counters. It is instantiated only under `ICACHE_STATS_EN`.

## Test plan
- **Cold miss then hit:**
  - Stimulus: after reset, `imemREN`=1, `imemaddr`=0x0000_0040; memory holds 0x2001_0005 with `iwait` held 2 cycles.
  - Expected: `iREN`=1 and `iaddr`=0x40 for 3 cycles, fill, then `ihit`=1 and `imemload`=0x2001_0005.
- **Conflict eviction:**
  - Stimulus: fill 0x0000_0004, then fetch 0x0000_0044 (same index, new tag).
  - Expected: a miss; after refill, fetching 0x04 misses again.
- **Address change mid-miss:**
  - Stimulus: miss on 0x0000_0010; change `imemaddr` to 0x0000_0020 while `iwait`=1.
  - Expected: `iaddr` stays 0x10 and frame[4] is filled with tag 0; the next cycle's miss targets 0x20.
- **Reset during MISS:**
  - Stimulus: assert `nRST`=1 while `iwait`=1.
  - Expected: `iREN`=0 next cycle, state `IDLE`, and a re-fetch of the same address misses.
- **Byte-offset ignore:**
  - Stimulus: after filling 0x0000_0008, fetch 0x0000_000B.
  - Expected: `ihit`=1 with the same data.
- **`ICACHE_STATS_EN`:**
  - Stimulus: 1 miss plus 4 hits.
  - Expected: `hit_count`=5 and `miss_count`=1, because the post-fill hit counts. Forcing a counter to 0xFFFF_FFFF and hitting again leaves it at 0xFFFF_FFFF.
